// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared widths, encodings and exception bit positions for the fetch/decode boundary
package if_id_stage_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [DATA_W-1:0] NOP_INST = ZERO_WORD;
  localparam int EXC_IADEL = 4;
  typedef enum logic {RUN, HOLD} skid_state_e;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: holds the IRAM word that arrives on the first stalled cycle until the stall releases
module fetch_skid
  import if_id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              resume,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] word,
  output logic              held
);
  skid_state_e state, state_d;
  // state register
  always_ff @(posedge clk)
    state <= rst ? RUN : state_d;
  // resume (unstall or flush) always wins; capture only matters while not resuming
  always_comb begin
    state_d = state;
    if (resume) state_d = RUN;
    else if (capture) state_d = HOLD;
  end
  // only the first stalled cycle carries a valid IRAM word, later ones are ignored
  always_ff @(posedge clk)
    if (rst) word <= ZERO_WORD;
    else if (state == RUN && capture && !resume) word <= rdata;
  assign held = (state == HOLD);
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with one-cycle IRAM latency, stall skid and flush bubbles
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_excp,
  input  logic              iram_en,
  input  logic [DATA_W-1:0] iram_rdata,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic [DATA_W-1:0] id_excp,
  output logic              id_valid
);
  logic [ADDR_W-1:0] s1_pc;
  logic [DATA_W-1:0] s1_excp, skid_word, src;
  logic              s1_valid, held;
  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .capture (stall),
    .resume  (!stall || flush),
    .rdata   (iram_rdata),
    .word    (skid_word),
    .held    (held)
  );
  assign src = held ? skid_word : iram_rdata;
  // request register: tracks which address the IRAM word arriving next cycle belongs to
  always_ff @(posedge clk)
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s1_pc    <= RESET_PC;
      s1_excp  <= ZERO_WORD;
    end else if (!stall) begin
      s1_valid <= iram_en;
      s1_pc    <= if_pc;
      s1_excp  <= if_excp;
    end
  // decode register: pairs s1 with its word, squashing misaligned fetches and stale words
  always_ff @(posedge clk)
    if (rst || flush) begin
      id_valid <= 1'b0;
      id_pc    <= RESET_PC;
      id_inst  <= NOP_INST;
      id_excp  <= ZERO_WORD;
    end else if (!stall) begin
      id_valid <= s1_valid;
      id_pc    <= s1_valid ? s1_pc : RESET_PC;
      id_excp  <= s1_valid ? s1_excp : ZERO_WORD;
      id_inst  <= (s1_valid && !s1_excp[EXC_IADEL]) ? src : NOP_INST;
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for if_id_stage
module tb_if_id_stage;
  import if_id_stage_pkg::*;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] IADEL = 32'h1 << EXC_IADEL;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] excp;
  } exp_t;
  logic clk = 0, rst = 1, stall = 0, flush = 0, iram_en = 0;
  logic [31:0] if_pc = 0, if_excp = 0, iram_rdata;
  logic [31:0] id_pc, id_inst, id_excp;
  logic id_valid;
  logic upd = 0;
  int total = 0, passed = 0;
  exp_t sb[$];

  if_id_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_excp(if_excp), .iram_en(iram_en), .iram_rdata(iram_rdata),
    .id_pc(id_pc), .id_inst(id_inst), .id_excp(id_excp), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h0000_0011;
      32'hBFC0_0004: return 32'h0000_0022;
      32'hBFC0_0008: return 32'h0000_0033;
      32'hBFC0_000C: return 32'h0000_0044;
      32'hBFC0_0380: return 32'h2408_0380;
      32'hBFC0_0384: return 32'h2409_0384;
      32'hBFC0_0002: return 32'hFFFF_FFFF;
      default:       return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  // IRAM model: word valid one cycle after an enabled read, garbage otherwise
  always @(posedge clk)
    iram_rdata <= iram_en ? mem_word(if_pc) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: every freshly loaded valid ID word must match the oldest expectation
  always @(negedge clk)
    if (upd && id_valid) begin
      if (sb.size() == 0) check("mon_unexpected_valid", id_pc, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_pc", id_pc, e.pc);
        check("mon_inst", id_inst, e.inst);
        check("mon_excp", id_excp, e.excp);
      end
    end

  task automatic step(input logic [31:0] pc, input logic [31:0] ex, input logic en,
                      input logic st, input logic fl);
    if_pc = pc;
    if_excp = ex;
    iram_en = en;
    stall = st;
    flush = fl;
    @(posedge clk);
    upd = rst || fl || !st;
    if (rst || fl) sb.delete();
    else if (en && !st) sb.push_back('{pc, ex[EXC_IADEL] ? 32'h0 : mem_word(pc), ex});
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(pc, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_id(input string name, input logic [31:0] pc, input logic [31:0] inst);
    check({name, "_valid"}, {31'h0, id_valid}, 32'h1);
    check({name, "_pc"}, id_pc, pc);
    check({name, "_inst"}, id_inst, inst);
  endtask

  task automatic expect_bubble(input string name);
    check({name, "_valid"}, {31'h0, id_valid}, 32'h0);
    check({name, "_pc"}, id_pc, RPC);
    check({name, "_inst"}, id_inst, 32'h0);
    check({name, "_excp"}, id_excp, 32'h0);
  endtask

  initial begin
    rst = 1;
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    expect_bubble("reset");
    rst = 0;
    fetch(32'hBFC0_0000);
    expect_bubble("lat1");
    fetch(32'hBFC0_0004);
    expect_id("seq0", 32'hBFC0_0000, 32'h11);
    fetch(32'hBFC0_0008);
    expect_id("seq1", 32'hBFC0_0004, 32'h22);
    fetch(32'hBFC0_000C);
    expect_id("seq2", 32'hBFC0_0008, 32'h33);
    rst = 1;
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 0;
    expect_bubble("rst2");
    fetch(32'hBFC0_0000);
    fetch(32'hBFC0_0004);
    expect_id("pre_stall", 32'hBFC0_0000, 32'h11);
    for (int i = 0; i < 3; i++) begin
      step(32'hBFC0_0008, 32'h0, 1'b0, 1'b1, 1'b0);
      expect_id("stall_hold", 32'hBFC0_0000, 32'h11);
    end
    fetch(32'hBFC0_0008);
    expect_id("skid_out", 32'hBFC0_0004, 32'h22);
    fetch(32'hBFC0_000C);
    expect_id("post_skid", 32'hBFC0_0008, 32'h33);
    step(32'hBFC0_0010, 32'h0, 1'b1, 1'b0, 1'b1);
    expect_bubble("flush1");
    fetch(32'hBFC0_0380);
    expect_bubble("flush2");
    fetch(32'hBFC0_0384);
    expect_id("flush_tgt", 32'hBFC0_0380, 32'h2408_0380);
    step(32'hBFC0_0002, IADEL, 1'b1, 1'b0, 1'b0);
    expect_id("tgt2", 32'hBFC0_0384, 32'h2409_0384);
    fetch(32'hBFC0_0010);
    expect_id("iadel", 32'hBFC0_0002, 32'h0);
    check("iadel_excp", id_excp, IADEL);
    step(32'hBFC0_0014, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_id("pre_nofetch", 32'hBFC0_0010, 32'hA5A5_0010);
    fetch(32'hBFC0_0018);
    expect_bubble("nofetch");
    fetch(32'hBFC0_001C);
    expect_id("post_nofetch", 32'hBFC0_0018, 32'hA5A5_0018);
    step(32'hBFC0_0020, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_id("hold2", 32'hBFC0_0018, 32'hA5A5_0018);
    step(32'hBFC0_0020, 32'h0, 1'b0, 1'b1, 1'b1);
    expect_bubble("flush_stall");
    fetch(32'hBFC0_0024);
    expect_bubble("flush_stall2");
    fetch(32'hBFC0_0028);
    expect_id("after_fs", 32'hBFC0_0024, 32'hA5A5_0024);
    step(32'hBFC0_002C, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_id("hold3", 32'hBFC0_0024, 32'hA5A5_0024);
    rst = 1;
    step(32'hBFC0_002C, 32'h0, 1'b0, 1'b1, 1'b0);
    rst = 0;
    expect_bubble("rst_hold");
    fetch(32'hBFC0_0030);
    expect_bubble("rst_hold2");
    fetch(32'hBFC0_0034);
    expect_id("post_rst", 32'hBFC0_0030, 32'hA5A5_0030);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_id("drain", 32'hBFC0_0034, 32'hA5A5_0034);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_bubble("drained");
    check("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; id_pc value driven during reset and bubbles.
REQ-002 SHALL have port clk, input, 1; single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset, synchronous and active-high.
REQ-004 SHALL have port stall, input, 1; IF/ID freeze, identical to the PC stage stall.
REQ-005 SHALL have port flush, input, 1; discard all fetch state, same cycle PC loads new_pc.
REQ-006 SHALL have port if_pc, input, 32; address presented to IRAM this cycle.
REQ-007 SHALL have port if_excp, input, 32; fetch exception vector for if_pc; bit EXC_IADEL is the misaligned-fetch flag.
REQ-008 SHALL have port iram_en, input, 1; IRAM read enable this cycle (equals !stall).
REQ-009 SHALL have port iram_rdata, input, 32; IRAM word, valid one cycle after an enabled read; not guaranteed held while iram_en=0.
REQ-010 SHALL have ports id_pc, id_inst, id_excp, output, 32 each; decode-stage PC, instruction, exception vector.
REQ-011 SHALL have port id_valid, output, 1; id_* carry a real instruction (0 = bubble).

Function
REQ-012 SHALL hold a request register (s1_pc, s1_excp, s1_valid) loaded from if_pc/if_excp with s1_valid=1 on any edge where iram_en=1, stall=0, flush=0.
REQ-013 SHALL produce the ID output registers one edge after the s1 register: fetch at cycle N gives id_* valid from cycle N+2; throughput 1 instruction/cycle without stall.
REQ-014 SHALL use a 2-state FSM, RUN and HOLD; the FSM is in RUN after reset.
REQ-015 In RUN with stall=1, SHALL capture iram_rdata into a skid register, move to HOLD, and hold s1 and id_* unchanged.
REQ-016 In HOLD with stall=1, SHALL leave skid, s1 and id_* unchanged and ignore iram_rdata.
REQ-017 On an edge with stall=0, SHALL load id_inst from skid if in HOLD, else from iram_rdata, load id_pc/id_excp/id_valid from s1, and go to RUN.
REQ-018 SHALL force id_inst to NOP (32'h0) whenever the source s1_excp has EXC_IADEL set, or s1_valid=0; id_excp SHALL still carry s1_excp.
REQ-019 On flush=1, SHALL clear s1_valid, force id_* to the bubble (id_pc=RESET_PC, id_inst=0, id_excp=0, id_valid=0), and go to RUN; flush overrides stall.
REQ-020 SHALL discard (not forward) the IRAM word returned in the cycle after a flush, because s1_valid=0 marks it stale.
REQ-021 SHALL treat iram_en=0 with stall=0 as no fetch: s1_valid becomes 0 and a bubble enters ID next edge.
REQ-022 SHALL perform no arithmetic on PC; all 32-bit fields pass through unmodified.

Reset
REQ-023 On rst=1 at a clock edge, SHALL set id_pc=RESET_PC, id_inst=0, id_excp=0, id_valid=0, s1_valid=0, skid=0, FSM=RUN; rst overrides flush and stall.
REQ-024 Reset asserted mid-HOLD SHALL drop the held word; the first valid output after release is the first fetch following reset.

Structure
REQ-025 ZeroWord, the NOP encoding, EXC_IADEL bit index, AddrBus and DataBus widths SHALL come from the shared defines file; no local redefinition.
REQ-026 The skid register plus the RUN/HOLD FSM SHALL be a sub-module fetch_skid, with ports: capture, release, rdata in, word out, held flag.
REQ-027 Total RTL SHALL be 120-400 lines, with no combinational path from iram_rdata to any output.

Verification
REQ-028 Straight-line fetch of PC 0xBFC00000, 0xBFC00004, 0xBFC00008 with mem words 0x11, 0x22, 0x33 -> id_pc/id_inst pairs appear on consecutive cycles starting 2 cycles after the first fetch, id_valid=1.
REQ-029 Stall 3 cycles while s1_pc=0xBFC00004; IRAM drives 0xDEADBEEF during stall cycles 2-3 -> id holds 0xBFC00000/0x11, then emits 0xBFC00004/0x22 (skid), not 0xDEADBEEF.
REQ-030 Flush with new_pc=0xBFC00380 while 0xBFC00008 is in flight -> next 2 ID cycles are bubbles (id_valid=0, id_inst=0), then 0xBFC00380 with its mem word; 0x33 never appears.
REQ-031 Fetch if_pc=0xBFC00002 with EXC_IADEL set, mem word 0xFFFFFFFF -> id_inst=0, id_excp[EXC_IADEL]=1, id_valid=1.
REQ-032 Flush and stall both high in HOLD -> bubble output, FSM=RUN, skid contents not emitted afterwards.
REQ-033 rst pulsed for 1 cycle during HOLD -> all outputs at reset values next cycle; first valid output is the post-reset fetch.
